// File: rtl/secded_128_pkg.sv
// Shared SECDED(137,128) constants and the data-to-code index mapping.
// The encoder and the decoder both use this package.
package secded_128_pkg;

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned CODE_W  = 137;
  localparam int unsigned NUM_CHK = 8;

  typedef logic [7:0] code_idx_t;
  typedef logic [DATA_W-1:0][7:0] data_idx_tbl_t;

  // Check bit c_j lives at Hamming position 2^j, i.e. code index 2^j - 1.
  localparam logic [NUM_CHK-1:0][7:0] CHK_IDX = {
    8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0
  };

  // Data bit d goes to the d-th non-power-of-two Hamming position (starting at p = 3).
  function automatic code_idx_t data_code_idx(int unsigned d);
    int unsigned n;
    n = 0;
    for (int unsigned p = 3; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == d) return code_idx_t'(p - 1);
        n++;
      end
    end
    return '0;
  endfunction

  function automatic data_idx_tbl_t build_data_code_idx();
    data_idx_tbl_t tbl;
    for (int unsigned d = 0; d < DATA_W; d++) begin
      tbl[d] = data_code_idx(d);
    end
    return tbl;
  endfunction

  localparam data_idx_tbl_t DATA_CODE_IDX = build_data_code_idx();

endpackage

// File: rtl/secded_128_chk_gen.sv
// Combinational Hamming check-bit generator: c_j is the XOR of the data bits whose
// Hamming position has bit j set.
module secded_128_chk_gen
  import secded_128_pkg::*;
(
  input  logic [0:DATA_W-1]  data_i,
  output logic [0:NUM_CHK-1] check_o
);

  logic [8:0] pos;

  always_comb begin
    check_o = '0;
    pos     = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pos = {1'b0, DATA_CODE_IDX[i]} + 9'd1;
      for (int j = 0; j < NUM_CHK; j++) begin
        if (pos[j]) begin
          check_o[j] = check_o[j] ^ data_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/secded_128_enc.sv
// SECDED(137,128) encoder: two-stage valid/ready pipeline with a saturating word counter.
// Defining SECDED_128_ENC_ERR_INJ_EN adds i_inj_mask/i_inj_en to corrupt the output word.
module secded_128_enc #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CODE_W = 137,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [0:DATA_W-1] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [0:CODE_W-1] o_code,
  output logic              o_valid,
  input  logic              i_ready,
`ifdef SECDED_128_ENC_ERR_INJ_EN
  input  logic [0:CODE_W-1] i_inj_mask,
  input  logic              i_inj_en,
`endif
  output logic [CNT_W-1:0]  o_count
);

  import secded_128_pkg::*;

  logic                s1_valid_q;
  logic [0:DATA_W-1]   s1_data_q;
  logic [0:NUM_CHK-1]  s1_check_q;
  logic [0:NUM_CHK-1]  check;
  logic [0:CODE_W-2]   ham;
  logic [0:CODE_W-1]   code_d;
  logic                s2_adv;
  logic                out_fire;

  secded_128_chk_gen u_chk_gen (
    .data_i  (i_data),
    .check_o (check)
  );

  // enable gates both stages and the output transfer, so a held word is never counted twice.
  assign s2_adv   = enable && (!o_valid || i_ready);
  assign out_fire = enable && o_valid && i_ready;
  assign o_ready  = !reset && enable && (!s1_valid_q || s2_adv);

  always_comb begin
    ham = '0;
    for (int j = 0; j < NUM_CHK; j++) begin
      ham[CHK_IDX[j]] = s1_check_q[j];
    end
    for (int i = 0; i < DATA_W; i++) begin
      ham[DATA_CODE_IDX[i]] = s1_data_q[i];
    end
`ifdef SECDED_128_ENC_ERR_INJ_EN
    code_d = {ham, ^ham} ^ (i_inj_en ? i_inj_mask : '0);
`else
    code_d = {ham, ^ham};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_check_q <= '0;
      o_valid    <= 1'b0;
      o_code     <= '0;
      o_count    <= '0;
    end else begin
      if (o_ready) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_data_q  <= i_data;
          s1_check_q <= check;
        end
      end
      if (s2_adv) begin
        o_valid <= s1_valid_q;
        if (s1_valid_q) begin
          o_code <= code_d;
        end
      end
      if (out_fire && !(&o_count)) begin
        o_count <= o_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_secded_128_enc.sv
// Self-checking bench for secded_128_enc: directed steps plus a scoreboard fed at input
// acceptance and drained at output transfer, with a behavioural SECDED decoder on the output.
module tb_secded_128_enc;

  typedef logic [0:127] data_t;
  typedef logic [0:136] code_t;
  typedef struct {
    code_t code;
    data_t data;
    logic  ce;
    logic  de;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, enable, i_valid, o_ready, o_valid, i_ready;
  data_t       i_data;
  code_t       o_code;
  logic [31:0] o_count;
  code_t       inj_mask;
  logic        inj_en;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  int          model_count;
  logic        prev_hold;
  code_t       prev_code;
  bit          stream_done;

  exp_t        pe, ce_item;
  data_t       dec_d;
  logic        dec_ce, dec_de;

  always #5 clk = ~clk;

  secded_128_enc dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_code     (o_code),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
`ifdef SECDED_128_ENC_ERR_INJ_EN
    .i_inj_mask (inj_mask),
    .i_inj_en   (inj_en),
`endif
    .o_count    (o_count)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_code(input string tag, input code_t obs, input code_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder built position by position from the Hamming definition.
  function automatic code_t encode_model(input data_t d);
    code_t c;
    int    k;
    logic  par;
    c = '0;
    k = 0;
    for (int p = 1; p <= 136; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 8; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 136; p++) begin
        if ((((p >> j) & 1) != 0) && ((p & (p - 1)) != 0)) par ^= c[p-1];
      end
      c[(1 << j) - 1] = par;
    end
    c[136] = ^c[0:135];
    return c;
  endfunction

  function automatic void decode_model(input code_t c, output data_t d, output logic ce,
                                       output logic de);
    int    syn;
    int    k;
    code_t cc;
    syn = 0;
    for (int p = 1; p <= 136; p++) if (c[p-1]) syn ^= p;
    cc = c;
    ce = 1'b0;
    de = 1'b0;
    if (^c) begin
      if (syn == 0) begin
        cc[136] = ~cc[136];
        ce = 1'b1;
      end else if (syn <= 136) begin
        cc[syn-1] = ~cc[syn-1];
        ce = 1'b1;
      end else begin
        de = 1'b1;
      end
    end else if (syn != 0) begin
      de = 1'b1;
    end
    d = '0;
    k = 0;
    for (int p = 1; p <= 136; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = cc[p-1];
        k++;
      end
    end
  endfunction

  // Output monitor: scoreboard push/pop, hold stability, counter model.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      model_count = 0;
      prev_hold   = 1'b0;
    end else begin
      if (prev_hold) begin
        chk_bit("hold_valid", o_valid, 1'b1);
        chk_code("hold_code", o_code, prev_code);
      end
      chk_int("count", int'(o_count), model_count);
      if (o_valid && i_ready && enable) begin
        if (sb.size() == 0) begin
          chk_bit("unexpected_word", o_valid, 1'b0);
        end else begin
          pe = sb.pop_front();
          chk_code("sb_code", o_code, pe.code);
          decode_model(o_code, dec_d, dec_ce, dec_de);
          chk_bit("dec_ce", dec_ce, pe.ce);
          chk_bit("dec_de", dec_de, pe.de);
          if (!pe.de) chk_code("dec_data", {dec_d, 9'h0}, {pe.data, 9'h0});
          model_count++;
        end
      end
      if (i_valid && o_ready) begin
        ce_item.data = i_data;
        ce_item.code = encode_model(i_data) ^ (inj_en ? inj_mask : '0);
        ce_item.ce   = inj_en && ($countones(inj_mask) == 1);
        ce_item.de   = inj_en && ($countones(inj_mask) == 2);
        sb.push_back(ce_item);
      end
      prev_hold = o_valid && !(i_ready && enable);
      prev_code = o_code;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was accepted.
  task automatic send(input data_t d);
    bit done;
    done    = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = o_ready;
    end
    if (!done) chk_bit("send_timeout", o_ready, 1'b1);
    step();
    i_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output code_t c);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = o_valid;
    end
    chk_bit({tag, "_valid"}, o_valid, 1'b1);
    c = o_code;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
    chk_int({tag, "_drain"}, sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic data_t rand_data();
    data_t d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    code_t got, exp_c;
    data_t d;
    int    a, b;

    reset = 1'b1; enable = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
    i_data = '1; inj_mask = '0; inj_en = 1'b0; stream_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_valid", o_valid, 1'b0);
    chk_bit("rst_ready", o_ready, 1'b0);
    chk_code("rst_code", o_code, '0);
    chk_int("rst_count", int'(o_count), 0);
    i_valid = 1'b0;
    step();
    reset = 1'b0;
    i_ready = 1'b1;

    // All-zero word: exact two-cycle latency and count of one.
    i_valid = 1'b1;
    i_data  = '0;
    @(negedge clk);
    chk_bit("zero_ready", o_ready, 1'b1);
    step();
    i_valid = 1'b0;
    @(negedge clk);
    chk_bit("lat1_valid", o_valid, 1'b0);
    @(negedge clk);
    chk_bit("lat2_valid", o_valid, 1'b1);
    chk_code("zero_code", o_code, '0);
    @(negedge clk);
    chk_int("zero_count", int'(o_count), 1);
    step();

    // Single data bit 127 (position 136).
    d = '0; d[127] = 1'b1;
    send(d);
    wait_out("d127", got);
    exp_c = '0; exp_c[7] = 1'b1; exp_c[127] = 1'b1; exp_c[135] = 1'b1; exp_c[136] = 1'b1;
    chk_code("d127_code", got, exp_c);
    step();

    // Single data bit 0 (position 3).
    d = '0; d[0] = 1'b1;
    send(d);
    wait_out("d0", got);
    exp_c = '0; exp_c[0] = 1'b1; exp_c[1] = 1'b1; exp_c[2] = 1'b1; exp_c[136] = 1'b1;
    chk_code("d0_code", got, exp_c);
    drain("d0");

    // Four back-to-back words with a three-cycle downstream stall.
    do_reset();
    i_ready = 1'b1;
    fork
      begin
        for (int w = 0; w < 4; w++) send(rand_data());
      end
      begin
        repeat (2) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain("stall");
    chk_int("stall_count", int'(o_count), 4);

    // enable low for five cycles with both stages full.
    do_reset();
    i_ready = 1'b1;
    send(rand_data());
    send(rand_data());
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_bit("en_ready", o_ready, 1'b0);
      chk_bit("en_valid", o_valid, 1'b1);
      step();
    end
    enable = 1'b1;
    drain("enable");
    chk_int("enable_count", int'(o_count), 2);

    // Reset with both stages full discards both words.
    do_reset();
    i_ready = 1'b0;
    send(rand_data());
    send(rand_data());
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk_bit("flush_valid", o_valid, 1'b0);
    chk_int("flush_count", int'(o_count), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_bit("no_stale", o_valid, 1'b0);
    end
    step();

    // Random loopback through the decoder model with random backpressure.
    do_reset();
    stream_done = 1'b0;
    fork
      begin
        for (int w = 0; w < 1000; w++) send(rand_data());
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1 i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_ready = 1'b1;
    drain("loop");
    chk_int("loop_count", int'(o_count), 1000);

`ifdef SECDED_128_ENC_ERR_INJ_EN
    // Masks change only with the pipeline empty, so the load-time mask equals the push-time one.
    step();
    inj_en = 1'b1;
    for (int w = 0; w < 20; w++) begin
      inj_mask = '0;
      inj_mask[$urandom_range(0, 136)] = 1'b1;
      send(rand_data());
      drain("inj1");
      step();
    end
    for (int w = 0; w < 20; w++) begin
      a = $urandom_range(0, 136);
      b = (a + $urandom_range(1, 136)) % 137;
      inj_mask = '0;
      inj_mask[a] = 1'b1;
      inj_mask[b] = 1'b1;
      send(rand_data());
      drain("inj2");
      step();
    end
    inj_en = 1'b0;
    inj_mask = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
